// File: rtl/debug_rx.sv
// ============================================================================
//  debug_rx : 8N1 UART receiver that assembles bytes into a packed text line
//  Revision : 1.0
// ============================================================================
`default_nettype none

module debug_rx #(
   parameter int CLK_HZ   = 25_000_000,
   parameter int BAUD     = 115200,
   parameter int TEXT_LEN = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic [8*TEXT_LEN-1:0] text,
   output logic [7:0]            text_len,
   output logic                  text_valid,
   input  logic                  text_ack,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int DIV_W        = $clog2(CLKS_PER_BIT + 1);
   localparam logic [DIV_W-1:0]      DIV_HALF = DIV_W'(CLKS_PER_BIT / 2);
   localparam logic [DIV_W-1:0]      DIV_FULL = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [8*TEXT_LEN-1:0] BLANK    = {TEXT_LEN{8'h20}};
   localparam logic [7:0]            LEN_FULL = 8'(TEXT_LEN);

   typedef enum logic [2:0] {
      ST_ARM   = 3'd0,
      ST_IDLE  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic              rx_meta, rx_s;
   logic [DIV_W-1:0]  div;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic [7:0]        cnt, cnt_nxt;
   logic              tick, load_half, sample, shift, byte_stb, stop_bad;
   logic              ack_now, is_term;
   logic [8*TEXT_LEN-1:0] text_nxt;
   logic [7:0]        len_nxt;
   logic              valid_nxt, ovr_nxt;

   // Synchroniser resets low so a line held low at reset release cannot look idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b0;
         rx_s    <= 1'b0;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   assign tick = (div == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_ARM;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_half = 1'b0;
      sample    = 1'b0;
      shift     = 1'b0;
      byte_stb  = 1'b0;
      stop_bad  = 1'b0;
      case (state)
         ST_ARM: begin
            if (rx_s) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (!rx_s) begin
               state_nxt = ST_START;
               load_half = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               sample    = 1'b1;
               state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               sample = 1'b1;
               shift  = 1'b1;
               if (bit_idx == 3'd7) state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               sample = 1'b1;
               if (rx_s) begin
                  byte_stb  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  stop_bad  = 1'b1;
                  state_nxt = ST_ARM;
               end
            end
         end
         default: state_nxt = ST_ARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div       <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'd0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         if (load_half)      div <= DIV_HALF;
         else if (sample)    div <= DIV_FULL;
         else if (!tick)     div <= div - DIV_W'(1);
         if (state == ST_START && sample) bit_idx <= 3'd0;
         if (shift) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   assign ack_now = text_ack & text_valid;
   assign is_term = (shreg == 8'h0D) || (shreg == 8'h0A);

   // The ack is applied before the strobe so a byte arriving with it opens the new line.
   always_comb begin
      text_nxt  = ack_now ? BLANK : text;
      valid_nxt = text_valid & ~ack_now;
      ovr_nxt   = overrun & ~ack_now;
      cnt_nxt   = cnt;
      len_nxt   = text_len;
      if (byte_stb) begin
         if (valid_nxt) begin
            ovr_nxt = 1'b1;
         end else if (is_term) begin
            if (cnt != 8'd0) begin
               valid_nxt = 1'b1;
               len_nxt   = cnt;
               cnt_nxt   = 8'd0;
            end
         end else begin
            for (int i = 0; i < TEXT_LEN; i++) begin
               if (cnt == 8'(i)) text_nxt[8*(TEXT_LEN-1-i) +: 8] = shreg;
            end
            if (cnt == LEN_FULL - 8'd1) begin
               valid_nxt = 1'b1;
               len_nxt   = LEN_FULL;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         text       <= BLANK;
         text_len   <= 8'd0;
         text_valid <= 1'b0;
         overrun    <= 1'b0;
         cnt        <= 8'd0;
      end else begin
         text       <= text_nxt;
         text_len   <= len_nxt;
         text_valid <= valid_nxt;
         overrun    <= ovr_nxt;
         cnt        <= cnt_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_debug_rx.sv
// Bench for debug_rx: vector table, directed corner sequences and random lines,
// all checked against a queue-based line model.
`default_nettype none

module tb_debug_rx;

   localparam int CPB = 16;
   localparam int TL  = 20;
   localparam logic [8*TL-1:0] BLANK = {TL{8'h20}};

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            uart_rx = 1'b1;
   logic            text_ack = 1'b0;
   logic [8*TL-1:0] text;
   logic [7:0]      text_len;
   logic            text_valid, frame_err, overrun;

   debug_rx #(.CLK_HZ(CPB*100_000), .BAUD(100_000), .TEXT_LEN(TL)) dut (
      .clk(clk), .reset(reset), .uart_rx(uart_rx), .text(text), .text_len(text_len),
      .text_valid(text_valid), .text_ack(text_ack), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int ferr_cnt = 0;

   always @(posedge clk) if (frame_err) ferr_cnt <= ferr_cnt + 1;

   // line model
   logic [7:0]      mq[$];
   logic            m_valid = 1'b0, m_ovr = 1'b0;
   logic [7:0]      m_len = 8'd0;
   logic [8*TL-1:0] m_text = BLANK;

   typedef struct {
      logic [31:0] msg;
      int          n;
      bit          do_ack;
   } vec_t;

   task automatic chk(input string nm, input logic [8*TL-1:0] act, input logic [8*TL-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      mq.delete();
      m_valid = 1'b0; m_ovr = 1'b0; m_len = 8'd0; m_text = BLANK;
   endtask

   task automatic deliver();
      m_text = BLANK;
      foreach (mq[i]) m_text[8*(TL-1-i) +: 8] = mq[i];
      m_len   = 8'(mq.size());
      m_valid = 1'b1;
      mq.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_valid) m_ovr = 1'b1;
      else if (b == 8'h0D || b == 8'h0A) begin
         if (mq.size() > 0) deliver();
      end else begin
         mq.push_back(b);
         if (mq.size() == TL) deliver();
      end
   endtask

   task automatic compare(input string nm);
      chk({nm, ".valid"},   text_valid, m_valid);
      chk({nm, ".len"},     text_len,   m_len);
      chk({nm, ".overrun"}, overrun,    m_ovr);
      if (m_valid) chk({nm, ".text"}, text, m_text);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop);
      uart_rx = 1'b0; tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i]; tick(CPB);
      end
      uart_rx = stop; tick(CPB);
      uart_rx = 1'b1; tick(CPB/2);
   endtask

   task automatic put_byte(input string nm, input logic [7:0] b);
      send_byte(b, 1'b1);
      model_byte(b);
      compare(nm);
   endtask

   task automatic do_ack(input string nm);
      text_ack = 1'b1; tick(1);
      text_ack = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0; m_ovr = 1'b0;
      end
      compare(nm);
   endtask

   vec_t vecs[6];
   int   f0;

   initial begin
      vecs[0] = '{msg: 32'(24'h4F4B0D), n: 3, do_ack: 1'b1};  // "OK\r"
      vecs[1] = '{msg: 32'(16'h0D0A),   n: 2, do_ack: 1'b1};  // empty line
      vecs[2] = '{msg: 32'(16'h580A),   n: 2, do_ack: 1'b0};  // "X\n", held
      vecs[3] = '{msg: 32'(16'h590A),   n: 2, do_ack: 1'b1};  // "Y\n" dropped
      vecs[4] = '{msg: 32'(16'h4142),   n: 2, do_ack: 1'b0};  // "AB"
      vecs[5] = '{msg: 32'(16'h430D),   n: 2, do_ack: 1'b1};  // "C\r" -> "ABC"

      // reset values, line held low through reset release
      uart_rx = 1'b0;
      tick(5);
      chk("rst.text",  text, BLANK);
      chk("rst.len",   text_len, 8'd0);
      chk("rst.valid", text_valid, 1'b0);
      chk("rst.ferr",  frame_err, 1'b0);
      chk("rst.ovr",   overrun, 1'b0);
      reset = 1'b0;
      tick(1000);
      uart_rx = 1'b1;
      tick(3*CPB);
      chk("low_release.ferr", 32'(ferr_cnt), 32'd0);
      compare("low_release");

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < vecs[v].n; k++)
            put_byte($sformatf("vec%0d.b%0d", v, k), vecs[v].msg[8*(vecs[v].n-1-k) +: 8]);
         if (vecs[v].do_ack) do_ack($sformatf("vec%0d.ack", v));
      end
      chk("ok.sample", text_len, 8'd3);

      // full line without terminator, then a trailing CRLF
      for (int k = 0; k < TL; k++) put_byte($sformatf("full.b%0d", k), 8'h41);
      chk("full.text_lit", text, {TL{8'h41}});
      do_ack("full.ack");
      put_byte("full.cr", 8'h0D);
      put_byte("full.lf", 8'h0A);

      // stop bit low
      f0 = ferr_cnt;
      send_byte(8'h55, 1'b0);
      tick(CPB);
      chk("ferr.pulses", 32'(ferr_cnt - f0), 32'd1);
      compare("ferr.after");
      put_byte("ferr.z", 8'h5A);
      put_byte("ferr.cr", 8'h0D);
      chk("ferr.zline", text[8*TL-1 -: 8], 8'h5A);
      do_ack("ferr.ack");

      // short glitch on idle line
      f0 = ferr_cnt;
      uart_rx = 1'b0; tick(CPB*3/10);
      uart_rx = 1'b1; tick(3*CPB);
      chk("glitch.ferr", 32'(ferr_cnt - f0), 32'd0);
      compare("glitch");
      put_byte("glitch.g", 8'h47);
      put_byte("glitch.cr", 8'h0D);
      do_ack("glitch.ack");

      // reset in the middle of a data phase
      uart_rx = 1'b0; tick(CPB);
      uart_rx = 1'b1; tick(CPB);
      uart_rx = 1'b0; tick(CPB);
      reset = 1'b1; uart_rx = 1'b1;
      tick(3);
      reset = 1'b0;
      model_reset();
      tick(CPB);
      chk("midrst.text", text, BLANK);
      compare("midrst");
      put_byte("midrst.q", 8'h51);
      put_byte("midrst.cr", 8'h0D);
      do_ack("midrst.ack");

      // random lines
      for (int r = 0; r < 8; r++) begin
         int len;
         len = (r == 7) ? TL : int'($urandom_range(1, TL-1));
         for (int k = 0; k < len; k++)
            put_byte($sformatf("rnd%0d.b%0d", r, k), 8'($urandom_range(8'h21, 8'h7E)));
         if (len < TL) put_byte($sformatf("rnd%0d.term", r), ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
         do_ack($sformatf("rnd%0d.ack", r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
